// File: rtl/boot_rom_overlay.sv
// Boot ROM overlay: maps a boot ROM over CPU addresses 0x0000..ROM_LAST
// until software writes a non-zero value to UNMAP_ADDR. All other reads
// and every write are forwarded to the external bus.
module boot_rom_overlay #(
    parameter logic [7:0]  ROM_LAST   = 8'hFF,
    parameter logic [15:0] UNMAP_ADDR = 16'hFF50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    output logic [7:0]  rom_ad,
    output logic        rom_ce,
    output logic        rom_oce,
    output logic        rom_reset,
    input  logic [7:0]  rom_dout,
    output logic [15:0] ext_addr,
    output logic        ext_rd,
    output logic        ext_wr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_rvalid,
    output logic        boot_active
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROM_WAIT = 2'd1,
        EXT_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_boot_active;
    logic [7:0]  r_rdata;
    logic        r_rvalid;
    logic        r_rom_sel;
    logic [7:0]  r_rom_ad;
    logic        r_rom_ce;
    logic [15:0] r_ext_addr;
    logic        r_ext_rd;
    logic        r_ext_wr;
    logic [7:0]  r_ext_wdata;

    state_t      w_state_nxt;
    logic        w_boot_nxt;
    logic [7:0]  w_rdata_nxt;
    logic        w_rvalid_nxt;
    logic        w_rom_sel_nxt;
    logic [7:0]  w_rom_ad_nxt;
    logic        w_rom_ce_nxt;
    logic [15:0] w_ext_addr_nxt;
    logic        w_ext_rd_nxt;
    logic        w_ext_wr_nxt;
    logic [7:0]  w_ext_wdata_nxt;
    logic        w_overlay;
    logic        w_unmap;

    // Overlay and unmap decodes use boot_active as registered at acceptance.
    assign w_overlay = r_boot_active && (cpu_addr <= {8'h00, ROM_LAST});
    assign w_unmap   = (cpu_addr == UNMAP_ADDR) && (cpu_wdata != 8'h00);

    // Next-state and next-output decode for the request FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_boot_nxt      = r_boot_active;
        w_rdata_nxt     = r_rom_sel ? rom_dout : r_rdata;
        w_rvalid_nxt    = 1'b0;
        w_rom_sel_nxt   = 1'b0;
        w_rom_ad_nxt    = r_rom_ad;
        w_rom_ce_nxt    = 1'b0;
        w_ext_addr_nxt  = r_ext_addr;
        w_ext_rd_nxt    = 1'b0;
        w_ext_wr_nxt    = 1'b0;
        w_ext_wdata_nxt = r_ext_wdata;
        case (r_state)
            IDLE: begin
                if (cpu_wr) begin
                    // A write wins over a simultaneous read; the read is dropped.
                    w_ext_wr_nxt    = 1'b1;
                    w_ext_addr_nxt  = cpu_addr;
                    w_ext_wdata_nxt = cpu_wdata;
                    if (w_unmap) begin
                        w_boot_nxt = 1'b0;
                    end
                end else if (cpu_rd) begin
                    if (w_overlay) begin
                        w_rom_ce_nxt = 1'b1;
                        w_rom_ad_nxt = cpu_addr[7:0];
                        w_state_nxt  = ROM_WAIT;
                    end else begin
                        w_ext_rd_nxt   = 1'b1;
                        w_ext_addr_nxt = cpu_addr;
                        w_state_nxt    = EXT_WAIT;
                    end
                end
            end
            ROM_WAIT: begin
                // ROM data appears in the same cycle as cpu_rvalid; the ROM's
                // own output register supplies it and it is latched afterwards.
                w_rvalid_nxt  = 1'b1;
                w_rom_sel_nxt = 1'b1;
                w_state_nxt   = IDLE;
            end
            EXT_WAIT: begin
                if (ext_rvalid) begin
                    w_rdata_nxt  = ext_rdata;
                    w_rvalid_nxt = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_boot_active <= 1'b1;
            r_rdata       <= '0;
            r_rvalid      <= 1'b0;
            r_rom_sel     <= 1'b0;
            r_rom_ad      <= '0;
            r_rom_ce      <= 1'b0;
            r_ext_addr    <= '0;
            r_ext_rd      <= 1'b0;
            r_ext_wr      <= 1'b0;
            r_ext_wdata   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_boot_active <= w_boot_nxt;
            r_rdata       <= w_rdata_nxt;
            r_rvalid      <= w_rvalid_nxt;
            r_rom_sel     <= w_rom_sel_nxt;
            r_rom_ad      <= w_rom_ad_nxt;
            r_rom_ce      <= w_rom_ce_nxt;
            r_ext_addr    <= w_ext_addr_nxt;
            r_ext_rd      <= w_ext_rd_nxt;
            r_ext_wr      <= w_ext_wr_nxt;
            r_ext_wdata   <= w_ext_wdata_nxt;
        end
    end

    assign cpu_ready   = (r_state == IDLE);
    assign cpu_rdata   = r_rom_sel ? rom_dout : r_rdata;
    assign cpu_rvalid  = r_rvalid;
    assign rom_ad      = r_rom_ad;
    assign rom_ce      = r_rom_ce;
    assign rom_oce     = r_rom_ce;
    assign rom_reset   = ~reset_n;
    assign ext_addr    = r_ext_addr;
    assign ext_rd      = r_ext_rd;
    assign ext_wr      = r_ext_wr;
    assign ext_wdata   = r_ext_wdata;
    assign boot_active = r_boot_active;

endmodule

// File: tb/tb_boot_rom_overlay.sv
// Directed self-checking bench for boot_rom_overlay.
module tb_boot_rom_overlay;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [7:0]  rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [7:0]  rom_dout = 8'h00;
    logic [15:0] ext_addr;
    logic        ext_rd;
    logic        ext_wr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_rvalid;
    logic        boot_active;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ext_rd = 0;
    int n_rvalid = 0;

    boot_rom_overlay #(.ROM_LAST(8'hFF), .UNMAP_ADDR(16'hFF50)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
        .rom_dout(rom_dout),
        .ext_addr(ext_addr), .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .boot_active(boot_active)
    );

    always #5 clk = ~clk;

    // Boot ROM model: synchronous read, contents = address XOR 0x06.
    always @(posedge clk) begin
        if (rom_ce) rom_dout <= rom_ad ^ 8'h06;
    end

    // Pulse counters for "never asserted" style checks.
    always @(posedge clk) begin
        if (ext_rd)     n_ext_rd++;
        if (cpu_rvalid) n_rvalid++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rom_read(input logic [15:0] a, input logic [7:0] exp, input string tag);
        int rd0;
        rd0 = n_ext_rd;
        cpu_addr = a; cpu_rd = 1'b1;
        tick;
        cpu_rd = 1'b0;
        check({tag, "_ce"},    {30'd0, rom_ce, rom_oce}, 32'd3);
        check({tag, "_ad"},    rom_ad, a[7:0]);
        check({tag, "_busy"},  cpu_ready, 1'b0);
        check({tag, "_early"}, cpu_rvalid, 1'b0);
        tick;
        check({tag, "_rv"},    cpu_rvalid, 1'b1);
        check({tag, "_data"},  cpu_rdata, exp);
        check({tag, "_ready"}, cpu_ready, 1'b1);
        tick;
        check({tag, "_rv_end"}, cpu_rvalid, 1'b0);
        check({tag, "_noext"},  n_ext_rd - rd0, 0);
    endtask

    task automatic ext_read(input logic [15:0] a, input int delay, input logic [7:0] d,
                            input logic drop, input string tag);
        cpu_addr = a; cpu_rd = 1'b1;
        tick;
        cpu_rd = 1'b0;
        check({tag, "_rd"},   ext_rd, 1'b1);
        check({tag, "_addr"}, ext_addr, a);
        check({tag, "_nocE"}, rom_ce, 1'b0);
        check({tag, "_busy"}, cpu_ready, 1'b0);
        for (int i = 0; i < delay; i++) begin
            if (drop && i == 1) begin
                cpu_addr = 16'h0000; cpu_rd = 1'b1;
            end
            tick;
            cpu_rd = 1'b0;
            check({tag, "_wait_busy"}, cpu_ready, 1'b0);
            check({tag, "_wait_rd"},   {30'd0, ext_rd, rom_ce}, 32'd0);
            check({tag, "_wait_rv"},   cpu_rvalid, 1'b0);
        end
        ext_rdata = d; ext_rvalid = 1'b1;
        tick;
        ext_rvalid = 1'b0;
        check({tag, "_rv"},    cpu_rvalid, 1'b1);
        check({tag, "_data"},  cpu_rdata, d);
        check({tag, "_ready"}, cpu_ready, 1'b1);
        tick;
        check({tag, "_rv_end"}, cpu_rvalid, 1'b0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic exp_boot,
                      input string tag);
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
        tick;
        cpu_wr = 1'b0;
        check({tag, "_wr"},    ext_wr, 1'b1);
        check({tag, "_addr"},  ext_addr, a);
        check({tag, "_wdata"}, ext_wdata, d);
        check({tag, "_ready"}, cpu_ready, 1'b1);
        check({tag, "_boot"},  boot_active, exp_boot);
        tick;
        check({tag, "_wr_end"}, ext_wr, 1'b0);
    endtask

    initial begin
        int rv0;
        reset_n = 1'b0; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
        ext_rdata = '0; ext_rvalid = 1'b0;
        tick; tick;
        check("rst_boot",   boot_active, 1'b1);
        check("rst_rdata",  cpu_rdata, 8'h00);
        check("rst_rvalid", cpu_rvalid, 1'b0);
        check("rst_strobe", {27'd0, ext_rd, ext_wr, rom_ce, rom_oce, cpu_rvalid}, 32'd0);
        check("rst_romad",  rom_ad, 8'h00);
        check("rst_eaddr",  ext_addr, 16'h0000);
        check("rst_ewdata", ext_wdata, 8'h00);
        check("rst_romrst", rom_reset, 1'b1);
        reset_n = 1'b1;
        tick;
        check("rel_ready",  cpu_ready, 1'b1);
        check("rel_romrst", rom_reset, 1'b0);

        rom_read(16'h0000, 8'h06, "rd0000");
        rom_read(16'h00FF, 8'hF9, "rd00FF");
        ext_read(16'h0100, 5, 8'hC3, 1'b1, "rd0100");

        // Stray ext_rvalid while idle.
        ext_rdata = 8'h99; ext_rvalid = 1'b1;
        tick;
        ext_rvalid = 1'b0;
        check("stray_rv", cpu_rvalid, 1'b0);
        check("stray_ready", cpu_ready, 1'b1);

        wr(16'h0010, 8'hAA, 1'b1, "wr0010");
        wr(16'hFF50, 8'h00, 1'b1, "unmap0");
        rom_read(16'h0005, 8'h03, "rd0005rom");
        wr(16'hFF50, 8'h01, 1'b0, "unmap1");
        ext_read(16'h0005, 1, 8'h5A, 1'b0, "rd0005ext");
        wr(16'hFF50, 8'h00, 1'b0, "sticky");

        // Reset in the middle of an external read.
        rv0 = n_rvalid;
        cpu_addr = 16'h0100; cpu_rd = 1'b1;
        tick;
        cpu_rd = 1'b0;
        check("mid_busy", cpu_ready, 1'b0);
        tick;
        reset_n = 1'b0;
        #1;
        check("mid_boot",  boot_active, 1'b1);
        check("mid_ready", cpu_ready, 1'b1);
        check("mid_rv",    cpu_rvalid, 1'b0);
        tick;
        reset_n = 1'b1;
        ext_rdata = 8'h77; ext_rvalid = 1'b1;
        tick;
        ext_rvalid = 1'b0;
        check("post_rst_rv", cpu_rvalid, 1'b0);
        tick;
        check("post_rst_cnt", n_rvalid - rv0, 0);
        rom_read(16'h0005, 8'h03, "rdpostrst");

        // Read and write together: only the write happens.
        rv0 = n_rvalid;
        cpu_addr = 16'hFF50; cpu_wdata = 8'h01; cpu_rd = 1'b1; cpu_wr = 1'b1;
        tick;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        check("both_wr",    ext_wr, 1'b1);
        check("both_nord",  {30'd0, ext_rd, rom_ce}, 32'd0);
        check("both_boot",  boot_active, 1'b0);
        check("both_ready", cpu_ready, 1'b1);
        tick; tick;
        check("both_norv",  n_rvalid - rv0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
